// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Handles byte/halfword/word accesses with sign/zero extension and read-modify-write sub-word stores.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | memory read, extended lane captured into resp_rdata
// WRITE  | full-word store
// RMW_RD | read word, merge store lane
// RMW_WR | write merged word
// RESP   | one-cycle completion pulse
module load_store_unit #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [1:0]            offset_q;
    logic [2:0]            funct3_q;
    logic [31:0]           data_q;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic                  req_err;
    logic [31:0]           rd_shifted;
    logic [31:0]           load_data;
    logic [31:0]           merged;

    always_comb begin
        req_err = |req_addr[31:ADDR_WIDTH+2];
        case (req_funct3)
            3'b000:  ;
            3'b100:  if (req_we) req_err = 1'b1;
            3'b001:  if (req_addr[0]) req_err = 1'b1;
            3'b101:  if (req_addr[0] || req_we) req_err = 1'b1;
            3'b010:  if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_shifted = mem_rd_data >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  load_data = {24'd0, rd_shifted[7:0]};
            3'b001:  load_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  load_data = {16'd0, rd_shifted[15:0]};
            default: load_data = mem_rd_data;
        endcase
    end

    // Only SB and SH reach RMW; funct3 bit 0 distinguishes them.
    always_comb begin
        merged = mem_rd_data;
        if (!funct3_q[0]) begin
            case (offset_q)
                2'd0: merged[7:0]   = data_q[7:0];
                2'd1: merged[15:8]  = data_q[7:0];
                2'd2: merged[23:16] = data_q[7:0];
                2'd3: merged[31:24] = data_q[7:0];
                default: ;
            endcase
        end else if (offset_q[1]) begin
            merged[31:16] = data_q[15:0];
        end else begin
            merged[15:0] = data_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            index_q  <= '0;
            offset_q <= '0;
            funct3_q <= '0;
            data_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        index_q  <= req_addr[ADDR_WIDTH+1:2];
                        offset_q <= req_addr[1:0];
                        funct3_q <= req_funct3;
                        data_q   <= req_wdata;
                        if (req_err) begin
                            rdata_q <= '0;
                            err_q   <= 1'b1;
                            state   <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_funct3 == 3'b010) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rdata_q <= load_data;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RMW_RD: begin
                    data_q <= merged;
                    state  <= RMW_WR;
                end
                RMW_WR: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high, before the synchronous reset lands.
    assign req_ready   = (state == IDLE) && !rst;
    assign resp_valid  = (state == RESP) && !rst;
    assign resp_rdata  = rst ? 32'd0 : rdata_q;
    assign resp_err    = err_q && !rst;
    assign mem_wr_en   = ((state == WRITE) || (state == RMW_WR)) && !rst;
    assign mem_address = rst ? '0 : index_q;
    assign mem_wr_data = rst ? 32'd0 : data_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_WIDTH, default 10, word-address width of the attached data_memory (capacity 4*2^ADDR_WIDTH bytes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents a load/store request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-012 resp_err  output  1  request rejected (misaligned, out of range or illegal code); valid with resp_valid.
REQ-013 mem_wr_en, mem_address[ADDR_WIDTH-1:0], mem_wr_data[31:0]  outputs  to data_memory; mem_rd_data[31:0]  input  combinational read data from data_memory.

Function
REQ-014 Request accepted on a rising edge where req_valid && req_ready; req_ready = 1 only in IDLE; one request in flight at most; no response backpressure.
REQ-015 Accept latches: word index = req_addr[ADDR_WIDTH+1:2], byte offset = req_addr[1:0], req_we, req_funct3, req_wdata.
REQ-016 Error when any of: req_addr[31:ADDR_WIDTH+2] != 0; H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 100 or 101.
REQ-017 States: IDLE, LOAD, WRITE, RMW_RD, RMW_WR, RESP.
REQ-018 IDLE on accept: error -> RESP; load -> LOAD; SW -> WRITE; SB/SH -> RMW_RD.
REQ-019 LOAD: mem_address = latched index, mem_wr_en = 0; end of cycle registers the selected byte/halfword lane of mem_rd_data, sign-extended (B,H) or zero-extended (BU,HU), or the full word (W), into resp_rdata; -> RESP.
REQ-020 WRITE: mem_wr_en = 1, mem_wr_data = latched wdata; -> RESP.
REQ-021 RMW_RD: read word at latched index; register merged word = read word with lane at the byte offset replaced by wdata[7:0] (SB) or wdata[15:0] (SH); all other bytes preserved; -> RMW_WR.
REQ-022 RMW_WR: mem_wr_en = 1, mem_wr_data = merged word; -> RESP.
REQ-023 RESP: resp_valid = 1 for exactly this cycle; resp_err = 1 only for error requests; -> IDLE.
REQ-024 Latency from accept edge to resp_valid: error 1 cycle; load and SW 2; SB/SH 3; next accept possible the cycle after RESP.
REQ-025 mem_wr_en = 1 only in WRITE and RMW_WR, never for error requests; mem_address holds the latched index in every non-IDLE state.
REQ-026 resp_rdata and resp_err hold their values until the next RESP; both are 0 in RESP for stores and errors.

Reset
REQ-027 While rst = 1: state IDLE, req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_wr_en = 0, mem_address = 0, mem_wr_data = 0.
REQ-028 rst asserted in any state aborts the request: no response, no memory write in that or any later cycle for it; req_ready = 1 the first cycle after rst deasserts.

Verification
REQ-029 SW 0x8 data 0xDEADBEEF -> mem_wr_en high one cycle with address 2, resp_valid at T+2 with err 0; then LW 0x8 -> resp_rdata 0xDEADBEEF at T+2.
REQ-030 SB 0x9 data 0x000000A5 on word 0xDEADBEEF -> word 2 = 0xDEADA5EF, resp at T+3; LB 0x9 -> 0xFFFFFFA5; LBU 0x9 -> 0x000000A5.
REQ-031 SH 0xA data 0x00001234 -> word 2 = 0x1234A5EF; LH 0xA -> 0x00001234; LH 0x8 -> 0xFFFFA5EF; LHU 0x8 -> 0x0000A5EF.
REQ-032 LW 0x6, SH 0x3, LW 0x1000, SB with funct3 100 -> each resp_err = 1, resp_rdata 0 at T+1, mem_wr_en never asserted, memory unchanged.
REQ-033 req_valid held high through back-to-back SB, LW -> req_ready low during SB, LW accepted the cycle after SB RESP, returns merged word.
REQ-034 rst pulsed during RMW_RD of an SB -> no resp_valid, mem_wr_en never asserted, all outputs 0 while rst high, req_ready = 1 the next cycle.
